// File: rtl/au_inc_pipe_if.sv
// Operand/result handshake bundle for au_inc_pipe.
// master = operand source + result consumer, slave = the incrementer pipeline.
interface au_inc_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             co;

    modport master (
        output in_valid, a, ci, out_ready,
        input  in_ready, out_valid, z, co
    );

    modport slave (
        input  in_valid, a, ci, out_ready,
        output in_ready, out_valid, z, co
    );
endinterface

// File: rtl/au_inc_pipe.sv
// Pipelined valid/ready incrementer z = a + ci, one WIDTH/STAGES segment per stage.
// Define AU_INC_PIPE_SAT_EN to make the last stage saturate z to all-ones on carry-out.

// Prefix-AND incrementer for one segment; ARCH: 0 serial, 1 Sklansky, 2 Kogge-Stone.
module au_inc_seg #(
    parameter int W    = 8,
    parameter int ARCH = 0
) (
    input  logic [W-1:0] a,
    input  logic         ci,
    output logic [W-1:0] z,
    output logic         co
);
    localparam int LV = (W > 1) ? $clog2(W) : 1;

    // pre[i] = &a[i:0]
    logic [W-1:0] pre;
    logic [W:0]   cv;

    if (ARCH == 0) begin : g_serial
        always_comb begin
            logic [W-1:0] p;
            p = '0;
            p[0] = a[0];
            for (int i = 1; i < W; i++) p[i] = p[i-1] & a[i];
            pre = p;
        end
    end else if (ARCH == 1) begin : g_sklansky
        always_comb begin
            logic [LV:0][W-1:0] g;
            g = '0;
            g[0] = a;
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < W; i++) begin
                    if (((i >> l) & 1) == 1)
                        g[l+1][i] = g[l][i] & g[l][((i >> (l+1)) << (l+1)) + (1 << l) - 1];
                    else
                        g[l+1][i] = g[l][i];
                end
            end
            pre = g[LV];
        end
    end else begin : g_kogge
        always_comb begin
            logic [LV:0][W-1:0] g;
            g = '0;
            g[0] = a;
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < W; i++) begin
                    if (i >= (1 << l)) g[l+1][i] = g[l][i] & g[l][i - (1 << l)];
                    else               g[l+1][i] = g[l][i];
                end
            end
            pre = g[LV];
        end
    end

    // carry into bit i is ci & all lower bits set; the top entry is the segment carry-out
    assign cv = {pre & {W{ci}}, ci};
    assign z  = a ^ cv[W-1:0];
    assign co = cv[W];
endmodule

module au_inc_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int ARCH   = 0
) (
    input  logic         clk,
    input  logic         rst,
    au_inc_pipe_if.slave bus
);
    localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || STAGES > NSEG) begin : g_bad_stages
        $error("au_inc_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end
    if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
        $error("au_inc_pipe: illegal ARCH=%0d", ARCH);
    end

    logic [STAGES:0] vld_pipe;
    assign vld_pipe[0] = bus.in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = ((((k + 1) * SEG) < WIDTH) ? ((k + 1) * SEG) : WIDTH) - 1;
        localparam int SW = HI - LO + 1;

        logic [WIDTH-1:0] d_in, d_nxt, d;
        logic             c_in, c, v;
        logic [SW-1:0]    s_z;
        logic             s_co;
        logic             ld, dn_rdy;

        if (k == 0) begin : g_src
            assign d_in = bus.a;
            assign c_in = bus.ci;
        end else begin : g_src
            assign d_in = g_stg[k-1].d;
            assign c_in = g_stg[k-1].c;
        end

        if (k == STAGES - 1) begin : g_dn
            assign dn_rdy = bus.out_ready;
        end else begin : g_dn
            assign dn_rdy = g_stg[k+1].ld;
        end

        // load when empty or when the current occupant leaves this cycle
        assign ld           = !v | dn_rdy;
        assign vld_pipe[k+1] = v;

        au_inc_seg #(.W(SW), .ARCH(ARCH)) u_seg (
            .a  (d_in[HI:LO]),
            .ci (c_in),
            .z  (s_z),
            .co (s_co)
        );

        always_comb begin
            d_nxt        = d_in;
            d_nxt[HI:LO] = s_z;
`ifdef AU_INC_PIPE_SAT_EN
            if (k == STAGES - 1 && s_co) d_nxt = '1;
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
                d <= '0;
                c <= 1'b0;
            end else if (ld) begin
                v <= vld_pipe[k];
                if (vld_pipe[k]) begin
                    d <= d_nxt;
                    c <= s_co;
                end
            end
        end
    end

    assign bus.in_ready  = g_stg[0].ld;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.z         = g_stg[STAGES-1].d;
    assign bus.co        = g_stg[STAGES-1].c;
endmodule

// File: tb/tb_au_inc_pipe.sv
// Directed bench for au_inc_pipe: reset, carry/wrap vectors, streaming, stall, flush,
// plus STAGES=1/4/16 variants checked against a reference model.
module tb_au_inc_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    au_inc_pipe_if #(.WIDTH(16)) bus  ();
    au_inc_pipe_if #(.WIDTH(16)) bus1 ();
    au_inc_pipe_if #(.WIDTH(16)) bus4 ();
    au_inc_pipe_if #(.WIDTH(16)) bus16();

    au_inc_pipe #(.WIDTH(16), .STAGES(2),  .ARCH(0)) dut     (.clk(clk), .rst(rst), .bus(bus));
    au_inc_pipe #(.WIDTH(16), .STAGES(1),  .ARCH(1)) dut_s1  (.clk(clk), .rst(rst), .bus(bus1));
    au_inc_pipe #(.WIDTH(16), .STAGES(4),  .ARCH(2)) dut_s4  (.clk(clk), .rst(rst), .bus(bus4));
    au_inc_pipe #(.WIDTH(16), .STAGES(16), .ARCH(2)) dut_s16 (.clk(clk), .rst(rst), .bus(bus16));

    // variant DUTs driven through arrays so one loop can handle all three
    logic [2:0]       x_iv, x_ci, x_or, x_ir, x_ov, x_co;
    logic [2:0][15:0] x_a, x_z;

    assign bus1.in_valid  = x_iv[0];  assign bus4.in_valid  = x_iv[1];  assign bus16.in_valid  = x_iv[2];
    assign bus1.a         = x_a[0];   assign bus4.a         = x_a[1];   assign bus16.a         = x_a[2];
    assign bus1.ci        = x_ci[0];  assign bus4.ci        = x_ci[1];  assign bus16.ci        = x_ci[2];
    assign bus1.out_ready = x_or[0];  assign bus4.out_ready = x_or[1];  assign bus16.out_ready = x_or[2];
    assign x_ir = {bus16.in_ready,  bus4.in_ready,  bus1.in_ready};
    assign x_ov = {bus16.out_valid, bus4.out_valid, bus1.out_valid};
    assign x_co = {bus16.co,        bus4.co,        bus1.co};
    assign x_z  = {bus16.z,         bus4.z,         bus1.z};

    function automatic logic [16:0] model(input logic [15:0] a, input logic ci);
        logic [16:0] s;
        s = {1'b0, a} + {16'b0, ci};
`ifdef AU_INC_PIPE_SAT_EN
        if (s[16]) s[15:0] = 16'hFFFF;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.z !== 16'h0000)    $display("FAIL reset_z got %h want 0000", bus.z); else pass_cnt++;
        chk_cnt++; if (bus.co !== 1'b0)       $display("FAIL reset_co got %b want 0", bus.co); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_single(input logic [15:0] a, input logic ci,
                               input logic [15:0] ez, input logic eco, input string nm);
        bus.a = a; bus.ci = ci; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL %s_in_ready got %b want 1", nm, bus.in_ready); else pass_cnt++;
        tick();
        bus.in_valid = 1'b0;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL %s_early_valid got %b want 0", nm, bus.out_valid); else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.out_valid !== 1'b1 || bus.z !== ez || bus.co !== eco)
            $display("FAIL %s_result got v=%b z=%h co=%b want v=1 z=%h co=%b", nm, bus.out_valid, bus.z, bus.co, ez, eco);
        else pass_cnt++;
        tick();
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL %s_dup got %b want 0", nm, bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        int n_in = 0, got = 0, first = -1, last = -1;
        bit acc, rdy_drop = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            bus.in_valid = (n_in < 100);
            bus.a        = 16'(n_in);
            bus.ci       = 1'b1;
            #1;
            if (bus.in_valid && !bus.in_ready) rdy_drop = 1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                chk_cnt++;
                if (bus.z !== 16'(got + 1) || bus.co !== 1'b0)
                    $display("FAIL stream_item%0d got z=%h co=%b want z=%h co=0", got, bus.z, bus.co, 16'(got + 1));
                else pass_cnt++;
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            tick();
            if (acc) n_in++;
        end
        bus.in_valid = 1'b0;
        chk_cnt++; if (rdy_drop)        $display("FAIL stream_in_ready dropped got 0 want 1"); else pass_cnt++;
        chk_cnt++; if (got !== 100)     $display("FAIL stream_count got %0d want 100", got); else pass_cnt++;
        chk_cnt++; if (first !== 2)     $display("FAIL stream_latency got %0d want 2", first); else pass_cnt++;
        chk_cnt++; if (last - first !== 99) $display("FAIL stream_contiguous got %0d want 99", last - first); else pass_cnt++;
    endtask

    task automatic test_stall_resume();
        localparam int N = 12;
        logic [16:0] exp_q[$];
        logic [16:0] e;
        logic [15:0] prev_z = '0;
        logic        prev_co = 1'b0;
        bit acc, prev_stall = 0;
        int n_in = 0, n_out = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.out_ready = (cyc < 5) ? 1'b0 : ((cyc % 3) != 0);
            bus.in_valid  = (n_in < N);
            bus.a         = 16'h00FC + 16'(n_in);
            bus.ci        = ((n_in % 3) != 0);
            #1;
            if (cyc == 4) begin
                chk_cnt++; if (n_in !== 2)           $display("FAIL stall_accepts got %0d want 2", n_in); else pass_cnt++;
                chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bus.in_ready); else pass_cnt++;
            end
            if (prev_stall) begin
                chk_cnt++;
                if (bus.out_valid !== 1'b1 || bus.z !== prev_z || bus.co !== prev_co)
                    $display("FAIL stall_hold cyc%0d got v=%b z=%h co=%b want v=1 z=%h co=%b",
                             cyc, bus.out_valid, bus.z, bus.co, prev_z, prev_co);
                else pass_cnt++;
            end
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) $display("FAIL stall_extra got z=%h want nothing", bus.z);
                else begin
                    e = exp_q.pop_front();
                    if ({bus.co, bus.z} !== e)
                        $display("FAIL stall_item%0d got co=%b z=%h want co=%b z=%h", n_out, bus.co, bus.z, e[16], e[15:0]);
                    else pass_cnt++;
                end
                n_out++;
            end
            if (acc) exp_q.push_back(model(bus.a, bus.ci));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_z     = bus.z;
            prev_co    = bus.co;
            tick();
            if (acc) n_in++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk_cnt++; if (n_out !== N)        $display("FAIL stall_count got %0d want %0d", n_out, N); else pass_cnt++;
        chk_cnt++; if (exp_q.size() !== 0) $display("FAIL stall_leftover got %0d want 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_flush();
        bit leaked = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.a = 16'hAAAA; bus.ci = 1'b1;
        tick();
        bus.a = 16'h5555;
        tick();
        bus.in_valid = 1'b0;
        chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL flush_loaded got %b want 1", bus.out_valid); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++;
        if (bus.out_valid !== 1'b0 || bus.z !== 16'h0000 || bus.co !== 1'b0)
            $display("FAIL flush_cleared got v=%b z=%h co=%b want v=0 z=0000 co=0", bus.out_valid, bus.z, bus.co);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) leaked = 1;
            tick();
        end
        chk_cnt++; if (leaked)               $display("FAIL flush_leak got an emitted operand want none"); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_variants();
        localparam int N = 40;
        logic [15:0] op_a[N];
        logic        op_c[N];
        logic [16:0] e;
        int n_in[3], n_out[3];
        bit acc[3];
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'($urandom);
            op_c[i] = 1'($urandom);
        end
        op_a[0] = 16'hFFFF; op_c[0] = 1'b1;
        op_a[1] = 16'h00FF; op_c[1] = 1'b1;
        op_a[2] = 16'h0FFF; op_c[2] = 1'b1;
        op_a[3] = 16'hFFFF; op_c[3] = 1'b0;
        op_a[4] = 16'h7FFF; op_c[4] = 1'b1;
        for (int j = 0; j < 3; j++) begin n_in[j] = 0; n_out[j] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int j = 0; j < 3; j++) begin
                x_iv[j] = (n_in[j] < N);
                x_a[j]  = (n_in[j] < N) ? op_a[n_in[j]] : 16'h0;
                x_ci[j] = (n_in[j] < N) ? op_c[n_in[j]] : 1'b0;
                x_or[j] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                acc[j] = x_iv[j] && x_ir[j];
                if (x_ov[j] && x_or[j]) begin
                    chk_cnt++;
                    if (n_out[j] >= N) $display("FAIL var%0d_extra got z=%h want nothing", j, x_z[j]);
                    else begin
                        e = model(op_a[n_out[j]], op_c[n_out[j]]);
                        if ({x_co[j], x_z[j]} !== e)
                            $display("FAIL var%0d_item%0d a=%h ci=%b got co=%b z=%h want co=%b z=%h", j, n_out[j],
                                     op_a[n_out[j]], op_c[n_out[j]], x_co[j], x_z[j], e[16], e[15:0]);
                        else pass_cnt++;
                    end
                    n_out[j]++;
                end
            end
            tick();
            for (int j = 0; j < 3; j++) if (acc[j]) n_in[j]++;
        end
        x_iv = '0;
        for (int j = 0; j < 3; j++) begin
            chk_cnt++; if (n_out[j] !== N) $display("FAIL var%0d_count got %0d want %0d", j, n_out[j], N); else pass_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.ci = 1'b0; bus.out_ready = 1'b1;
        x_iv = '0; x_a = '0; x_ci = '0; x_or = '1;
        test_reset();
        test_single(16'h00FF, 1'b1, 16'h0100, 1'b0, "carry_seg");
`ifdef AU_INC_PIPE_SAT_EN
        test_single(16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "wrap_sat");
`else
        test_single(16'hFFFF, 1'b1, 16'h0000, 1'b1, "wrap");
`endif
        test_single(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, "ones_ci0");
        test_single(16'h1234, 1'b0, 16'h1234, 1'b0, "ci0");
        test_single(16'h7FFF, 1'b1, 16'h8000, 1'b0, "msb_carry");
        test_single(16'h0000, 1'b1, 16'h0001, 1'b0, "zero_inc");
        test_stream();
        test_stall_resume();
        test_reset_flush();
        test_variants();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
